masked_ascon_sbox_layer_seq: RTL
================================

# masked_ascon_sbox_layer_seq

First-order masked Ascon substitution layer. It applies the 5-bit masked S-box to all W columns of a two-share 320-bit Ascon state, one column at a time, through a single `dom_ascon_sbox` instance. It sits between the round-constant addition and the linear diffusion layer of the masked permutation datapath. It trades area for latency, and feeds fresh randomness to each column.

## Interface
- `W`, default 64: number of columns, equal to lane width. Legal range is 2..64.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  input state shares are valid.
- `in_ready`  out  1  block can accept a state. Asserted only in IDLE.
- `ax_state`  in  5*W  share A of the input state. Lane xL occupies bits `[L*W +: W]`.
- `bx_state`  in  5*W  share B of the input state, same layout as `ax_state`.
- `rnd`  in  5  fresh randomness for one column.
- `rnd_req`  out  1  pulse: `rnd` is sampled on this clock edge.
- `out_valid`  out  1  result shares are valid.
- `out_ready`  in  1  consumer accepts the result.
- `ay_state`  out  5*W  share A of the result, same layout as `ax_state`.
- `by_state`  out  5*W  share B of the result, same layout as `ax_state`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Input handshake: a state is accepted when `in_valid && in_ready`. On acceptance, both shares are copied into the working registers and the column counter `col` is set to 0.
- Column mapping: for column c, S-box input `ax[4-L] = ax_state[L*W + c]`, and likewise for share B. The output maps back the same way, so lane x0 is S-box bit 4.
- S-box contract: share inputs and `z` are held stable for two consecutive cycles. The S-box output is valid in the second cycle.
- States:
  - IDLE: `in_ready` = 1. On accept, go to PRESENT.
  - PRESENT: drive column `col` onto the S-box. Latch `rnd` into `z_q`. Assert `rnd_req`. Next state is HOLD.
  - HOLD: keep driving the same column and `z_q`. At the end of the cycle, write the S-box output into result bit `col`.
    - If `col == W-1`, go to DONE.
    - Otherwise increment `col`, then go to FLUSH (if enabled) or PRESENT.
  - FLUSH: drive all-zero shares and `z` = 0 for one cycle, then go to PRESENT.
  - DONE: `out_valid` = 1, and the result registers are held. On `out_ready`, go to IDLE.
- Share separation:
  - Share A and share B registers are never combined outside the S-box instance.
  - Result registers update only in HOLD.
  - Randomness is consumed exactly once per column, W samples per state.
- Reset values: `in_ready` = 0 while `rst` is asserted and 1 after release. `out_valid`, `rnd_req`, `busy`, `ay_state`, `by_state`, `col`, `z_q` and all working registers are 0.
- Reset mid-operation: the FSM returns to IDLE immediately, all partial results are cleared, and no `out_valid` is produced.
- `in_valid` while busy is ignored; the caller holds it until `in_ready`.
- `out_ready` asserted outside DONE has no effect.
- A new accept is possible in the cycle after the DONE handshake. There is no same-cycle turnaround.

## Timing
- Without flush: accept at edge 0, `out_valid` rises after edge 2W+1. For W=64 this is 129 cycles.
- With flush: there are 3W-1 column cycles, so `out_valid` rises after edge 3W. For W=64 this is 192 cycles.
- `rnd_req` is high for exactly one cycle per column, in PRESENT.
- Outputs are registered, with no combinational path from inputs to outputs.
- Throughput is one state per latency+1 cycles.

## Configuration
- `ASCON_SBOX_SEQ_FLUSH_EN`
  - Defined: the FLUSH state is compiled in. Zero shares sit between columns to stop glitch and transition coupling between consecutive columns.
  - Undefined: the FLUSH state and its encoding are absent. HOLD goes straight to PRESENT, with the latencies given above.

## Structure
- Shared package `ascon_mask_pkg` holds:
  - the FSM state enum;
  - `ASCON_LANES` = 5;
  - lane-index constants (X0..X4);
  - the lane-to-S-box-bit mapping function.
- Exactly one sub-module: `dom_ascon_sbox`, instantiated once. There is no other hierarchy.

## Test plan
- All-zero state, random masks: the recombined output has lane x2 = all ones and the other lanes all zero (S(0x00)=0x04). `out_valid` arrives at the latency given above.
- Column c = 5 only, with unmasked x4 bit 5 = 1 (S(0x01)=0x0B): recombined lanes x1, x3, x4 have bit 5 set, and every other bit of those lanes equals the all-zero case.
- The same unmasked state is sent twice with different masks and `rnd` streams. The recombined outputs are identical, and the share values differ.
- Hold `out_ready` = 0 for 10 cycles in DONE:
  - outputs stay stable and `out_valid` stays high;
  - `in_ready` stays 0;
  - a new accept occurs the cycle after `out_ready`.
- Assert `rst` at column 17: all outputs become 0 asynchronously, and the FSM restarts from IDLE. A following full run matches the golden model.
- Across a full run, count `rnd_req` pulses: the count is exactly W, with no pulses in IDLE or DONE.

Source files
------------

// File: rtl/ascon_mask_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ascon_mask_pkg
//  Description : Shared definitions for the masked Ascon datapath: lane count,
//                lane indices, sequencer state encoding and the mapping from
//                state lane to S-box input bit.
//                Build macro: ASCON_SBOX_SEQ_FLUSH_EN adds the FLUSH state.
//  Revision    : 1.0  initial release
// ============================================================================
package ascon_mask_pkg;

  localparam int ASCON_LANES = 5;

  localparam int X0 = 0;
  localparam int X1 = 1;
  localparam int X2 = 2;
  localparam int X3 = 3;
  localparam int X4 = 4;

  // Column sequencer states; FLUSH and its code exist only in flush builds
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRESENT = 3'd1,
    S_HOLD    = 3'd2,
    S_DONE    = 3'd3
`ifdef ASCON_SBOX_SEQ_FLUSH_EN
    , S_FLUSH = 3'd4
`endif
  } sbox_seq_state_t;

  // Lane xL drives S-box bit 4-L, so x0 is the S-box MSB
  function automatic int lane_to_sbox_bit(input int lane);
    return X4 - lane;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dom_ascon_sbox.sv
`default_nettype none
// ============================================================================
//  Module      : dom_ascon_sbox
//  Description : First-order DOM-masked 5-bit Ascon S-box. Linear layers are
//                applied per share; each chi AND uses one fresh bit of z on
//                its registered cross-domain terms. Inputs and z must be held
//                for two cycles; outputs are valid in the second cycle.
//                Bit 4 of each port is lane x0.
//  Revision    : 1.0  initial release
// ============================================================================
module dom_ascon_sbox (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ax,
  input  logic [4:0] bx,
  input  logic [4:0] z,
  output logic [4:0] ay,
  output logic [4:0] by
);

  // Internal vectors are indexed by lane: [i] is x_i
  logic [4:0] w_xa, w_xb, w_la, w_lb, w_la_rot, w_lb_rot;
  logic [4:0] w_ta, w_tb, w_ca, w_cb, w_ya, w_yb;
  logic [4:0] r_cross_a, r_cross_b;

  // Input linear layer per share; rot[i] = l[i+1 mod 5]
  always_comb begin
    w_xa     = {ax[0], ax[1], ax[2], ax[3], ax[4]};
    w_xb     = {bx[0], bx[1], bx[2], bx[3], bx[4]};
    w_la     = {w_xa[4] ^ w_xa[3], w_xa[3], w_xa[2] ^ w_xa[1], w_xa[1], w_xa[0] ^ w_xa[4]};
    w_lb     = {w_xb[4] ^ w_xb[3], w_xb[3], w_xb[2] ^ w_xb[1], w_xb[1], w_xb[0] ^ w_xb[4]};
    w_la_rot = {w_la[0], w_la[4:1]};
    w_lb_rot = {w_lb[0], w_lb[4:1]};
  end

  // Cross-domain products are remasked with z and registered before use
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cross_a <= '0;
      r_cross_b <= '0;
    end else begin
      r_cross_a <= (~w_la & w_lb_rot) ^ z;
      r_cross_b <= (w_lb & w_la_rot) ^ z;
    end
  end

  // Inner-domain products, chi, output linear layer; NOT applied to share A only
  always_comb begin
    w_ta = (~w_la & w_la_rot) ^ r_cross_a;
    w_tb = (w_lb & w_lb_rot) ^ r_cross_b;
    w_ca = w_la ^ {w_ta[0], w_ta[4:1]};
    w_cb = w_lb ^ {w_tb[0], w_tb[4:1]};
    w_ya = {w_ca[4], w_ca[3] ^ w_ca[2], ~w_ca[2], w_ca[1] ^ w_ca[0], w_ca[0] ^ w_ca[4]};
    w_yb = {w_cb[4], w_cb[3] ^ w_cb[2],  w_cb[2], w_cb[1] ^ w_cb[0], w_cb[0] ^ w_cb[4]};
    ay   = {w_ya[0], w_ya[1], w_ya[2], w_ya[3], w_ya[4]};
    by   = {w_yb[0], w_yb[1], w_yb[2], w_yb[3], w_yb[4]};
  end

endmodule
`default_nettype wire

// File: rtl/masked_ascon_sbox_layer_seq.sv
`default_nettype none
// ============================================================================
//  Module      : masked_ascon_sbox_layer_seq
//  Description : Two-share Ascon substitution layer, one column at a time
//                through a single DOM S-box. Each column is presented for two
//                cycles with a fresh rnd sample; results collect bit by bit.
//                Build macro: ASCON_SBOX_SEQ_FLUSH_EN inserts an all-zero
//                FLUSH cycle between columns.
//  Revision    : 1.0  initial release
// ============================================================================
module masked_ascon_sbox_layer_seq
  import ascon_mask_pkg::*;
#(
  parameter int W = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [5*W-1:0] ax_state,
  input  logic [5*W-1:0] bx_state,
  input  logic [4:0]     rnd,
  output logic           rnd_req,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [5*W-1:0] ay_state,
  output logic [5*W-1:0] by_state,
  output logic           busy
);

  localparam int             C_CW       = (W > 1) ? $clog2(W) : 1;
  localparam logic [C_CW-1:0] C_COL_LAST = C_CW'(W - 1);

  sbox_seq_state_t r_state, w_next_state;
  logic [C_CW-1:0] r_col;
  logic [4:0]      r_z;
  logic            r_in_ready, r_out_valid, r_rnd_req, r_busy;
  logic            w_accept, w_col_last;
  wire  [4:0]      w_col_a, w_col_b;
  logic [4:0]      w_sb_ax, w_sb_bx, w_sb_z, w_sb_ay, w_sb_by;

  assign w_accept   = in_valid && r_in_ready;
  assign w_col_last = (r_col == C_COL_LAST);
  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign rnd_req    = r_rnd_req;
  assign busy       = r_busy;

  // State register; handshake flags are registered decodes of the next state,
  // out_valid is a registered decode of DONE so it trails DONE entry by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_rnd_req   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_in_ready  <= (w_next_state == S_IDLE);
      r_rnd_req   <= (w_next_state == S_PRESENT);
      r_busy      <= (w_next_state != S_IDLE);
      r_out_valid <= (r_state == S_DONE) && (w_next_state == S_DONE);
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:    if (w_accept) w_next_state = S_PRESENT;
      S_PRESENT: w_next_state = S_HOLD;
      S_HOLD: begin
        if (w_col_last) w_next_state = S_DONE;
`ifdef ASCON_SBOX_SEQ_FLUSH_EN
        else            w_next_state = S_FLUSH;
`else
        else            w_next_state = S_PRESENT;
`endif
      end
`ifdef ASCON_SBOX_SEQ_FLUSH_EN
      S_FLUSH:   w_next_state = S_PRESENT;
`endif
      S_DONE:    if (out_ready && r_out_valid) w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // S-box drive: current column in PRESENT/HOLD, zeros otherwise (incl. FLUSH);
  // z is rnd while it is being sampled, then the latched copy
  always_comb begin
    w_sb_ax = '0;
    w_sb_bx = '0;
    w_sb_z  = '0;
    if (r_state == S_PRESENT) begin
      w_sb_ax = w_col_a;
      w_sb_bx = w_col_b;
      w_sb_z  = rnd;
    end else if (r_state == S_HOLD) begin
      w_sb_ax = w_col_a;
      w_sb_bx = w_col_b;
      w_sb_z  = r_z;
    end
  end

  // Column counter and randomness latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_z   <= '0;
    end else begin
      if (w_accept) r_col <= '0;
      else if (r_state == S_HOLD && !w_col_last) r_col <= r_col + 1'b1;
      if (r_state == S_PRESENT) r_z <= rnd;
    end
  end

  dom_ascon_sbox u_sbox (
    .clk (clk),
    .rst (rst),
    .ax  (w_sb_ax),
    .bx  (w_sb_bx),
    .z   (w_sb_z),
    .ay  (w_sb_ay),
    .by  (w_sb_by)
  );

  for (genvar l = 0; l < ASCON_LANES; l++) begin : g_lane
    localparam int C_SB = lane_to_sbox_bit(l);
    logic [W-1:0] r_ax, r_bx, r_ay, r_by;

    // Working shares load on accept; result bit col written only in HOLD
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_ax <= '0;
        r_bx <= '0;
        r_ay <= '0;
        r_by <= '0;
      end else begin
        if (w_accept) begin
          r_ax <= ax_state[l*W +: W];
          r_bx <= bx_state[l*W +: W];
        end
        if (r_state == S_HOLD) begin
          r_ay[r_col] <= w_sb_ay[C_SB];
          r_by[r_col] <= w_sb_by[C_SB];
        end
      end
    end

    assign w_col_a[C_SB]      = r_ax[r_col];
    assign w_col_b[C_SB]      = r_bx[r_col];
    assign ay_state[l*W +: W] = r_ay;
    assign by_state[l*W +: W] = r_by;
  end

endmodule
`default_nettype wire
